// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: bit order, blank pattern, slot phases
// and the hex-to-segment lookup used by encoders and benches.
package seg7_pkg;

  // Segment bit positions within a 7-bit pattern (bit6..bit0 = g..a).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Phase of the current digit slot.
  typedef enum logic {
    PH_GUARD,
    PH_ON
  } slot_phase_t;

  // Logical (1 = lit) segment pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit slot timer: cnt counts cycles within a slot, idx selects the digit.
// Reports the guard phase and the last cycle of the frame.
module seg7_slot_timer import seg7_pkg::*; #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  localparam int AW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          in_guard,
  output logic [AW-1:0] idx,
  output logic          frame_boundary
);

  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          idx_last;

  assign cnt_last       = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_last       = (idx == AW'(NUM_DIGITS - 1));
  assign in_guard       = (cnt < CW'(GUARD));
  assign frame_boundary = cnt_last && idx_last;

  // Slot counter wraps every REFRESH_DIV cycles and advances the digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + AW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a shadow buffer
// that is copied to the display only at frame boundaries, and per-slot
// blanking to avoid ghosting.
module seg7_scan_driver import seg7_pkg::*; #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter int ACTIVE_LOW  = 1,
  localparam int AW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [6:0]            wr_seg,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [6:0]            shadow [NUM_DIGITS];
  logic [6:0]            disp   [NUM_DIGITS];
  logic                  in_guard;
  logic [AW-1:0]         idx;
  logic                  frame_boundary;
  logic                  apply;
  slot_phase_t           phase;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  seg7_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .in_guard      (in_guard),
    .idx           (idx),
    .frame_boundary(frame_boundary)
  );

  assign apply = frame_boundary && (commit_pending || commit);

  // Shadow buffer: in-range writes always land here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '{default: SEG_BLANK};
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      shadow[wr_addr] <= wr_seg;
    end
  end

  // Display buffer takes the pre-write shadow contents at a committed frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp <= '{default: SEG_BLANK};
    end else if (apply) begin
      disp <= shadow;
    end
  end

  // Pending flag: set by commit, cleared when the copy happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_pending <= 1'b0;
    end else if (apply) begin
      commit_pending <= 1'b0;
    end else if (commit) begin
      commit_pending <= 1'b1;
    end
  end

  // Slot phase from the timer.
  always_comb begin
    phase = in_guard ? PH_GUARD : PH_ON;
  end

  // Logical pin values: blank during guard, current digit otherwise.
  always_comb begin
    an_next  = '0;
    seg_next = SEG_BLANK;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (phase == PH_ON && idx == AW'(d)) begin
        an_next[d] = 1'b1;
        seg_next   = disp[d];
      end
    end
  end

  // Output register applies physical pin polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= (ACTIVE_LOW != 0) ? ~seg_next : seg_next;
      an         <= (ACTIVE_LOW != 0) ? ~an_next  : an_next;
      frame_tick <= frame_boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit instance and a 3-digit
// instance (for the out-of-range address case) sharing clock and reset.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [6:0] wr_seg = '0;
  logic       commit = 1'b0;
  logic       commit_pending;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  logic       wr_en3 = 1'b0;
  logic [1:0] wr_addr3 = '0;
  logic [6:0] wr_seg3 = '0;
  logic       commit3 = 1'b0;
  logic       commit_pending3;
  logic [6:0] seg3;
  logic [2:0] an3;
  logic       frame_tick3;

  int n_checks = 0;
  int n_fails  = 0;
  int k        = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .GUARD      (2),
    .ACTIVE_LOW (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_seg        (wr_seg),
    .commit        (commit),
    .commit_pending(commit_pending),
    .seg           (seg),
    .an            (an),
    .frame_tick    (frame_tick)
  );

  seg7_scan_driver #(
    .NUM_DIGITS (3),
    .REFRESH_DIV(8),
    .GUARD      (2),
    .ACTIVE_LOW (1)
  ) dut3 (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en3),
    .wr_addr       (wr_addr3),
    .wr_seg        (wr_seg3),
    .commit        (commit3),
    .commit_pending(commit_pending3),
    .seg           (seg3),
    .an            (an3),
    .frame_tick    (frame_tick3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s (edge %0d): observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    chk("rst_cp", 32'(commit_pending), 32'h0);
    chk("rst_an3", 32'(an3), 32'h7);
    release_reset();

    // Run A: uncommitted write on dut; out-of-range write + commit on dut3.
    wr_en = 1'b1; wr_addr = 2'd1; wr_seg = 7'h06;
    wr_en3 = 1'b1; wr_addr3 = 2'd3; wr_seg3 = 7'h7F;
    tick();                                   // edge 1
    wr_en = 1'b0;
    wr_addr3 = 2'd1; wr_seg3 = 7'h06;
    tick();                                   // edge 2
    wr_en3 = 1'b0; commit3 = 1'b1;
    chk("a_an_e2", 32'(an), 32'hF);
    tick();                                   // edge 3
    commit3 = 1'b0;
    chk("a_an_e3", 32'(an), 32'hE);
    chk("a_seg_e3", 32'(seg), 32'h7F);
    chk("a_cp3_e3", 32'(commit_pending3), 32'h1);
    run_to(8);  chk("a_an_e8", 32'(an), 32'hE);
    run_to(9);  chk("a_an_e9", 32'(an), 32'hF);
    run_to(10); chk("a_an_e10", 32'(an), 32'hF);
    run_to(11);
    chk("a_an_e11", 32'(an), 32'hD);
    chk("a_seg_e11", 32'(seg), 32'h7F);
    run_to(23); chk("a_cp3_e23", 32'(commit_pending3), 32'h1);
    run_to(24);
    chk("a_cp3_e24", 32'(commit_pending3), 32'h0);
    chk("a_ft3_e24", 32'(frame_tick3), 32'h1);
    run_to(27);
    chk("a_an3_e27", 32'(an3), 32'h6);
    chk("a_seg3_e27", 32'(seg3), 32'h7F);
    run_to(32); chk("a_ft_e32", 32'(frame_tick), 32'h1);
    run_to(33); chk("a_ft_e33", 32'(frame_tick), 32'h0);
    run_to(35);
    chk("a_an3_e35", 32'(an3), 32'h5);
    chk("a_seg3_e35", 32'(seg3), 32'h79);
    run_to(43);
    chk("a_an_e43", 32'(an), 32'hD);
    chk("a_seg_e43", 32'(seg), 32'h7F);
    chk("a_cp_e43", 32'(commit_pending), 32'h0);
    chk("a_an3_e43", 32'(an3), 32'h3);
    chk("a_seg3_e43", 32'(seg3), 32'h7F);
    run_to(51);
    chk("a_an3_e51", 32'(an3), 32'h6);
    chk("a_seg3_e51", 32'(seg3), 32'h7F);

    // Run B: commit, same-cycle collision, later commit, mid-slot reset.
    rst = 1'b1;
    release_reset();
    wr_en = 1'b1; wr_addr = 2'd0; wr_seg = 7'h3F;
    tick();                                   // edge 1
    wr_addr = 2'd1; wr_seg = 7'h06;
    tick();                                   // edge 2
    wr_addr = 2'd2; wr_seg = 7'h5B;
    tick();                                   // edge 3
    wr_addr = 2'd3; wr_seg = 7'h4F;
    tick();                                   // edge 4
    wr_en = 1'b0;
    run_to(5);
    chk("b_cp_e5", 32'(commit_pending), 32'h0);
    commit = 1'b1;
    tick();                                   // edge 6
    commit = 1'b0;
    chk("b_cp_e6", 32'(commit_pending), 32'h1);
    run_to(31);
    chk("b_cp_e31", 32'(commit_pending), 32'h1);
    chk("b_ft_e31", 32'(frame_tick), 32'h0);
    wr_en = 1'b1; wr_addr = 2'd0; wr_seg = 7'h66; commit = 1'b1;
    tick();                                   // edge 32
    wr_en = 1'b0; commit = 1'b0;
    chk("b_cp_e32", 32'(commit_pending), 32'h0);
    chk("b_ft_e32", 32'(frame_tick), 32'h1);
    run_to(33); chk("b_ft_e33", 32'(frame_tick), 32'h0);
    run_to(35);
    chk("b_an_e35", 32'(an), 32'hE);
    chk("b_seg_e35", 32'(seg), 32'h40);
    run_to(39);
    commit = 1'b1;
    tick();                                   // edge 40
    commit = 1'b0;
    chk("b_seg_e40", 32'(seg), 32'h40);
    chk("b_cp_e40", 32'(commit_pending), 32'h1);
    run_to(41);
    chk("b_an_e41", 32'(an), 32'hF);
    chk("b_seg_e41", 32'(seg), 32'h7F);
    run_to(43);
    chk("b_an_e43", 32'(an), 32'hD);
    chk("b_seg_e43", 32'(seg), 32'h79);
    run_to(51);
    chk("b_an_e51", 32'(an), 32'hB);
    chk("b_seg_e51", 32'(seg), 32'h24);
    run_to(59);
    chk("b_an_e59", 32'(an), 32'h7);
    chk("b_seg_e59", 32'(seg), 32'h30);
    run_to(63); chk("b_cp_e63", 32'(commit_pending), 32'h1);
    run_to(64);
    chk("b_cp_e64", 32'(commit_pending), 32'h0);
    chk("b_ft_e64", 32'(frame_tick), 32'h1);
    run_to(67);
    chk("b_an_e67", 32'(an), 32'hE);
    chk("b_seg_e67", 32'(seg), 32'h19);
    run_to(77);
    chk("b_an_e77", 32'(an), 32'hD);
    chk("b_seg_e77", 32'(seg), 32'h79);
    commit = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    commit = 1'b0;
    chk("b_async_an", 32'(an), 32'hF);
    chk("b_async_seg", 32'(seg), 32'h7F);
    chk("b_async_cp", 32'(commit_pending), 32'h0);
    release_reset();
    run_to(2);  chk("b_rs_an_e2", 32'(an), 32'hF);
    run_to(3);
    chk("b_rs_an_e3", 32'(an), 32'hE);
    chk("b_rs_seg_e3", 32'(seg), 32'h7F);
    run_to(11);
    chk("b_rs_an_e11", 32'(an), 32'hD);
    chk("b_rs_seg_e11", 32'(seg), 32'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
